intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt controller for the multicycle MCU; it is the responder end of the intrpt_vld / int_taken handshake that the control-unit FSM initiates.
- Synchronizes external interrupt lines, latches rising edges as pending, masks them and selects one by fixed priority.
- Presents a single registered intrpt_vld plus a stable source ID to the CU, and retires the pending bit when the CU pulses int_taken.

Parameters:
- NUM_SRC, 4, number of external interrupt sources (1..16).
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= NUM_SRC.
- SYNC_STAGES, 2, flip-flop synchronizer depth per source (>=2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_in  in  NUM_SRC  asynchronous external interrupt lines.
- irq_mask  in  NUM_SRC  per-source enable; 1 = enabled.
- mie  in  1  global interrupt enable from the CSR file.
- int_taken  in  1  one-cycle acknowledge from the CU (its interrupt state).
- intrpt_vld  out  1  interrupt request to the CU; registered.
- irq_id  out  ID_W  index of the source being requested or serviced.
- pend  out  NUM_SRC  raw pending bits, unmasked, for CSR read-back.
- spurious_ack  out  1  sticky flag: int_taken arrived while no request was outstanding.

Behaviour:
- Reset (rst_n low, asynchronous): synchronizers, edge-history regs and pend = 0; intrpt_vld = 0, irq_id = 0, spurious_ack = 0; state = IDLE. Reset mid-handshake abandons the request; no pending bit survives.
- Sync: each irq_in bit passes through SYNC_STAGES flops. The edge detector compares sync output with its previous value.
- Pending: a rising edge on source i sets pend[i] on the next clk edge.
  - pend[i] clears only when that source is acknowledged.
  - If set and clear coincide on the same bit in the same cycle, set wins; pend[i] stays 1.
- Eligible vector = pend & irq_mask, gated by mie. Priority is fixed, lowest index first.
- FSM states:
  - IDLE: intrpt_vld = 0. If any source is eligible, latch the winner into irq_id, set intrpt_vld = 1 and go to REQ.
  - REQ: intrpt_vld = 1 and irq_id held stable; a newly pending higher-priority source does not replace it.
    - On int_taken: clear pend[irq_id], set intrpt_vld = 0, go to HOLD.
    - Else, if mie = 0 or irq_mask[irq_id] = 0: set intrpt_vld = 0, go to IDLE, pend unchanged (request withdrawn).
  - HOLD: intrpt_vld = 0 for exactly one cycle, irq_id retained, then go to IDLE. This keeps the CU's next FETCH/EXEC from seeing a stale request.
- int_taken in IDLE or HOLD sets spurious_ack, which stays set until reset. No other effect.
- Latency (SYNC_STAGES = 2):
  - irq_in rises and is stable before edge 1.
  - pend[i] = 1 after edge 3.
  - intrpt_vld = 1 after edge 4 (SYNC_STAGES + 2 edges in general).
- Ack to next request: minimum 2 cycles (REQ → HOLD → IDLE → REQ).
- irq_id is never undefined: it holds its last value outside REQ.
- A pulse on irq_in shorter than one clk period may be lost; this is documented and not an error.

Optional Feature:
- Macro: INTR_CTRL_LEVEL_EN.
- Defined: sources are level-sensitive. The edge detector and pend latch are removed, and pend = synchronized irq_in. int_taken does not clear pend; the handler silences the source. HOLD remains, so a still-asserted level re-requests two cycles after the ack.
- Undefined: edge-triggered latching as above.

Test Plan:
- Reset/idle: rst_n low mid-REQ with irq_in = 4'b0010 → next cycle intrpt_vld = 0, pend = 0, irq_id = 0, spurious_ack = 0; after rst_n rises, the steady-high line produces no new request.
- Single edge: mask = 4'hF, mie = 1, irq_in[2] rises → pend = 4'b0100 after 3 edges, intrpt_vld = 1 with irq_id = 2 after 4 edges. int_taken pulse → pend = 0, intrpt_vld = 0, and it stays 0 for ≥2 cycles.
- Priority/stability: irq_in[3] rises; during REQ (irq_id = 3) irq_in[0] rises → irq_id stays 3 until int_taken. Two cycles later intrpt_vld = 1 with irq_id = 0.
- Masking/withdraw: in REQ for source 1, drop mie → intrpt_vld = 0 next cycle and pend[1] still 1. Raise mie → request returns with irq_id = 1.
- Set/clear collision: new edge on source 1 lands the same cycle int_taken acks source 1 → pend[1] = 1 afterwards and a second request follows. Separately, an int_taken pulse in IDLE → spurious_ack = 1 and it stays 1.
- Level mode (INTR_CTRL_LEVEL_EN defined): hold irq_in[0] = 1 → int_taken, HOLD, then re-request with irq_id = 0. Drop irq_in[0] → no further request.

Source files
------------

// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: request/acknowledge handshake between the interrupt controller and the control unit
interface intr_ctrl_if #(
    parameter int ID_W = 2
);
    logic            intrpt_vld;
    logic [ID_W-1:0] irq_id;
    logic            int_taken;
    modport master (output int_taken, input intrpt_vld, irq_id);
    modport slave (input int_taken, output intrpt_vld, irq_id);
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: synchronized, fixed-priority interrupt controller; INTR_CTRL_LEVEL_EN selects level-sensitive sources
module intr_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in_i,
    input  logic [NUM_SRC-1:0] irq_mask_i,
    input  logic               mie_i,
    output logic [NUM_SRC-1:0] pend_o,
    output logic               spurious_ack_o,
    intr_ctrl_if.slave         cu
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2;
    logic [1:0]         state_q, state_d;
    logic               vld_q, vld_d, spur_q, spur_d, any;
    logic [ID_W-1:0]    id_q, id_d, win;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] irq_s, pend, elig;
    assign irq_s = sync_q[SYNC_STAGES-1];
    // per-source flop chain bringing the asynchronous lines into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= irq_in_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end
`ifdef INTR_CTRL_LEVEL_EN
    assign pend = irq_s;
`else
    logic [NUM_SRC-1:0] prev_q, pend_q, rise, clr;
    logic [SYNC_STAGES:0] fill_q;
    // edges are ignored until the synchronizer and history hold real samples, so a line already high at reset release is not mistaken for a new edge
    assign rise = fill_q[SYNC_STAGES] ? irq_s & ~prev_q : '0;
    assign clr  = (state_q == REQ && cu.int_taken) ? NUM_SRC'(1) << id_q : '0;
    // edge history and pending latch; a new edge beats a same-cycle acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            pend_q <= '0;
            fill_q <= '0;
        end else begin
            prev_q <= irq_s;
            pend_q <= (pend_q & ~clr) | rise;
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end
    assign pend = pend_q;
`endif
    assign elig = pend & irq_mask_i & {NUM_SRC{mie_i}};
    assign any  = |elig;
    // lowest eligible index wins
    always_comb begin
        win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) if (elig[i]) win = ID_W'(i);
    end
    // request handshake: IDLE -> REQ until taken or withdrawn, then one HOLD cycle so the CU never sees a stale request
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        id_d    = id_q;
        spur_d  = spur_q | (cu.int_taken && state_q != REQ);
        case (state_q)
            IDLE: if (any) begin
                state_d = REQ;
                vld_d   = 1'b1;
                id_d    = win;
            end
            REQ: if (cu.int_taken) begin
                state_d = HOLD;
                vld_d   = 1'b0;
            end else if (!mie_i || !irq_mask_i[id_q]) begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end
    // handshake state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            id_q    <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            spur_q  <= spur_d;
        end
    end
    assign cu.intrpt_vld  = vld_q;
    assign cu.irq_id      = id_q;
    assign pend_o         = pend;
    assign spurious_ack_o = spur_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scenarios plus randomized traffic against a cycle-level behavioural model
module tb_intr_ctrl;
    localparam int N = 4;
    localparam int S = 2;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq = '0;
    logic [N-1:0] mask = '1;
    logic         mie = 1'b1;
    logic         taken = 1'b0;
    logic [N-1:0] pend_o;
    logic         spurious_ack_o;
    int           total = 0;
    int           bad = 0;
    logic [N-1:0] hist [$];
    int           age;
    bit           m_vld, m_hold, m_spur;
    int           m_id;
    logic [N-1:0] m_pend;

    intr_ctrl_if #(.ID_W(2)) cu_if ();
    assign cu_if.int_taken = taken;

    intr_ctrl #(.NUM_SRC(N), .ID_W(2), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in_i(irq), .irq_mask_i(mask), .mie_i(mie),
        .pend_o(pend_o), .spurious_ack_o(spurious_ack_o), .cu(cu_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        for (int k = 0; k <= S; k++) hist.push_back('0);
        age = 0; m_vld = 0; m_hold = 0; m_spur = 0; m_id = 0; m_pend = '0;
    endtask

    // one clock edge of the controller's observable behaviour, from the pre-edge inputs
    task automatic model_edge();
        logic [N-1:0] el, rise;
        int w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        el = m_pend & mask & {N{mie}};
        w = -1;
        for (int i = N - 1; i >= 0; i--) if (el[i]) w = i;
`ifdef INTR_CTRL_LEVEL_EN
        rise = '0;
`else
        rise = (age >= S + 1) ? hist[S-1] & ~hist[S] : '0;
`endif
        if (m_vld) begin
            if (taken) begin
                m_vld = 0;
                m_hold = 1;
`ifndef INTR_CTRL_LEVEL_EN
                m_pend[m_id] = 1'b0;
`endif
            end else if (!mie || !mask[m_id]) m_vld = 0;
        end else begin
            if (taken) m_spur = 1;
            if (m_hold) m_hold = 0;
            else if (w >= 0) begin
                m_vld = 1;
                m_id = w;
            end
        end
        m_pend |= rise;
        hist.push_front(irq);
        void'(hist.pop_back());
`ifdef INTR_CTRL_LEVEL_EN
        m_pend = hist[S-1];
`endif
        age++;
    endtask

    task automatic compare();
        chk("vld", 32'(cu_if.intrpt_vld), 32'(m_vld));
        chk("id", 32'(cu_if.irq_id), m_id);
        chk("pend", 32'(pend_o), 32'(m_pend));
        chk("spur", 32'(spurious_ack_o), 32'(m_spur));
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            compare();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic ack();
        taken = 1'b1;
        tick();
        taken = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();
        tick(4);
`ifdef INTR_CTRL_LEVEL_EN
        irq = 4'b0001;
        tick(3);
        chk("lvl_req", 32'(cu_if.intrpt_vld), 1);
        chk("lvl_id", 32'(cu_if.irq_id), 0);
        ack();
        chk("lvl_hold", 32'(cu_if.intrpt_vld), 0);
        chk("lvl_pend", 32'(pend_o), 1);
        tick(2);
        chk("lvl_rereq", 32'(cu_if.intrpt_vld), 1);
        irq = '0;
        ack();
        tick(5);
        chk("lvl_quiet", 32'(cu_if.intrpt_vld), 0);
`else
        irq = 4'b0010;
        tick(4);
        chk("pre_rst_vld", 32'(cu_if.intrpt_vld), 1);
        chk("pre_rst_id", 32'(cu_if.irq_id), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_vld", 32'(cu_if.intrpt_vld), 0);
        chk("rst_pend", 32'(pend_o), 0);
        chk("rst_id", 32'(cu_if.irq_id), 0);
        chk("rst_spur", 32'(spurious_ack_o), 0);
        tick();
        rst_n = 1'b1;
        tick(8);
        chk("steady_high_vld", 32'(cu_if.intrpt_vld), 0);
        chk("steady_high_pend", 32'(pend_o), 0);
        irq = 4'b0110;
        tick(3);
        chk("edge_pend", 32'(pend_o), 4'b0100);
        chk("edge_novld", 32'(cu_if.intrpt_vld), 0);
        tick();
        chk("edge_vld", 32'(cu_if.intrpt_vld), 1);
        chk("edge_id", 32'(cu_if.irq_id), 2);
        ack();
        chk("ack_pend", 32'(pend_o), 0);
        chk("ack_vld", 32'(cu_if.intrpt_vld), 0);
        tick(2);
        chk("ack_quiet", 32'(cu_if.intrpt_vld), 0);
        irq = 4'b1110;
        tick(4);
        chk("pri_id3", 32'(cu_if.irq_id), 3);
        irq = 4'b1111;
        tick(4);
        chk("pri_stable", 32'(cu_if.irq_id), 3);
        chk("pri_pend", 32'(pend_o), 4'b1001);
        ack();
        tick();
        chk("pri_gap", 32'(cu_if.intrpt_vld), 0);
        tick();
        chk("pri_next_vld", 32'(cu_if.intrpt_vld), 1);
        chk("pri_next_id", 32'(cu_if.irq_id), 0);
        ack();
        irq = 4'b1101;
        tick(3);
        irq = 4'b1111;
        tick(4);
        chk("wd_id", 32'(cu_if.irq_id), 1);
        mie = 1'b0;
        tick();
        chk("wd_vld", 32'(cu_if.intrpt_vld), 0);
        chk("wd_pend", 32'(pend_o), 4'b0010);
        mie = 1'b1;
        tick();
        chk("wd_back_vld", 32'(cu_if.intrpt_vld), 1);
        chk("wd_back_id", 32'(cu_if.irq_id), 1);
        irq = 4'b1101;
        tick(3);
        irq = 4'b1111;
        tick(2);
        ack();
        chk("coll_pend", 32'(pend_o), 4'b0010);
        tick(2);
        chk("coll_rereq", 32'(cu_if.intrpt_vld), 1);
        chk("coll_id", 32'(cu_if.irq_id), 1);
        ack();
        tick(2);
        chk("spur_clear", 32'(spurious_ack_o), 0);
        ack();
        chk("spur_set", 32'(spurious_ack_o), 1);
        tick(3);
        chk("spur_sticky", 32'(spurious_ack_o), 1);
`endif
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 3) == 0) irq ^= N'(1 << $urandom_range(0, N - 1));
                if ($urandom_range(0, 15) == 0) mask = N'($urandom);
                mie = ($urandom_range(0, 9) != 0);
                taken = ($urandom_range(0, 3) == 0);
                tick();
            end
            taken = 1'b0;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
